// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer width, output buffer depth, and pointer distance math.
package fifo_pkg;

    localparam int unsigned OUTBUF_DEPTH = 2;

    // Pointer width for a given address width: one extra wrap bit.
    function automatic int unsigned ptr_w(input int unsigned aw);
        return aw + 1;
    endfunction

    // Word count between two wrap-bit pointers: (a - b) mod 2^(aw+1).
    function automatic logic [31:0] ptr_count(input logic [31:0] a_ptr,
                                              input logic [31:0] b_ptr,
                                              input int unsigned aw);
        logic [31:0] mask;
        mask = (32'(1) << (aw + 1)) - 32'(1);
        return (a_ptr - b_ptr) & mask;
    endfunction

endpackage

// File: rtl/read_control_fwft_if.sv
// Output-side valid/ready data channel of the FWFT read controller.
interface read_control_fwft_if #(
    parameter int unsigned DW = 32
) ();
    logic          o_valid_d;
    logic [DW-1:0] o_data_d;
    logic          i_ready_d;

    modport master (output o_valid_d, output o_data_d, input i_ready_d);
    modport slave  (input o_valid_d, input o_data_d, output i_ready_d);
endinterface

// File: rtl/fifo_out_buf.sv
// Two-entry register buffer: tail write, head pop, occupancy count.
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 wr_en,
    input  logic [DW-1:0]                        wr_data,
    input  logic                                 pop,
    output logic [$clog2(OUTBUF_DEPTH+1)-1:0]    occ,
    output logic [DW-1:0]                        head_data
);

    localparam int unsigned OCC_W = $clog2(OUTBUF_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(OUTBUF_DEPTH);

    logic [DW-1:0]    ent [OUTBUF_DEPTH];
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;

    // Entry storage and index/occupancy bookkeeping; write and pop may coincide.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(OUTBUF_DEPTH); i++) begin
                ent[i] <= '0;
            end
            head_idx <= '0;
            tail_idx <= '0;
            occ      <= '0;
        end else begin
            if (wr_en) begin
                ent[tail_idx] <= wr_data;
            end
            tail_idx <= tail_idx + IDX_W'(wr_en);
            head_idx <= head_idx + IDX_W'(pop);
            occ      <= occ + OCC_W'(wr_en) - OCC_W'(pop);
        end
    end

    assign head_data = ent[head_idx];

endmodule

// File: rtl/read_control_fwft.sv
// FIFO read controller: owns the read pointer, prefetches into a 2-entry buffer, FWFT output.
module read_control_fwft
    import fifo_pkg::*;
#(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [AW:0]               i_wptr,
    input  logic [AW-1:0]             i_almostempty_lvl,
    input  logic [DW-1:0]             i_rdata,
    output logic [AW:0]               o_rptr,
    output logic [AW-1:0]             o_raddr,
    output logic                      o_ren,
    output logic                      o_mem_empty,
    output logic                      o_empty,
    output logic                      o_almostempty,
    read_control_fwft_if.master       dout
);

    localparam int unsigned PW    = ptr_w(AW);
    localparam int unsigned OCC_W = $clog2(OUTBUF_DEPTH + 1);

    logic [PW-1:0]    rptr;
    logic [PW-1:0]    mem_count;
    logic             inflight;
    logic             pop;
    logic [OCC_W-1:0] occ;
    logic [2:0]       credit_used;

    // Memory status from the current write pointer only.
    assign mem_count     = PW'(ptr_count(32'(i_wptr), 32'(rptr), AW));
    assign o_mem_empty   = (i_wptr == rptr);
    assign o_almostempty = (mem_count <= {1'b0, i_almostempty_lvl});

    // Issue a read only if the buffer can absorb it after this cycle's pop.
    assign pop         = dout.o_valid_d & dout.i_ready_d;
    assign credit_used = 3'(occ) + 3'(inflight) - 3'(pop);
    assign o_ren       = ~o_mem_empty & (credit_used < 3'd2);

    // Read pointer advance and one-cycle read-latency tracking.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rptr     <= '0;
            inflight <= 1'b0;
        end else begin
            rptr     <= rptr + PW'(o_ren);
            inflight <= o_ren;
        end
    end

    assign o_rptr  = rptr;
    assign o_raddr = rptr[AW-1:0];
    assign o_empty = o_mem_empty & ~inflight & (occ == '0);

    assign dout.o_valid_d = (occ != '0);

    fifo_out_buf #(
        .DW (DW)
    ) u_out_buf (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .wr_en     (inflight),
        .wr_data   (i_rdata),
        .pop       (pop),
        .occ       (occ),
        .head_data (dout.o_data_d)
    );

endmodule

// File: tb/tb_read_control_fwft.sv
// Self-checking bench for read_control_fwft: directed scenarios plus randomized traffic vs a queue model.
module tb_read_control_fwft;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW:0]   wptr;
    logic [AW-1:0] lvl;
    logic [DW-1:0] rdata;
    logic [AW:0]   rptr;
    logic [AW-1:0] raddr;
    logic          ren;
    logic          mem_empty;
    logic          empty;
    logic          almostempty;

    read_control_fwft_if #(.DW(DW)) dif ();

    read_control_fwft #(.AW(AW), .DW(DW)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_wptr            (wptr),
        .i_almostempty_lvl (lvl),
        .i_rdata           (rdata),
        .o_rptr            (rptr),
        .o_raddr           (raddr),
        .o_ren             (ren),
        .o_mem_empty       (mem_empty),
        .o_empty           (empty),
        .o_almostempty     (almostempty),
        .dout              (dif.master)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory model, 1-cycle latency.
    logic [DW-1:0] mem [8];
    always @(posedge clk) begin
        if (ren) rdata <= mem[raddr];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wptr = '0;
        lvl = '0;
        dif.i_ready_d = 1'b0;
        #22;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Observe for a fixed window; expect n_exp words base..base+n_exp-1 on consecutive cycles.
    task automatic collect(input string tag, input int cycles, input logic [7:0] base, input int n_exp);
        int n;
        int first;
        int last;
        logic [7:0] expd;
        n = 0; first = -1; last = -1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (dif.o_valid_d && dif.i_ready_d) begin
                expd = base + 8'(n);
                check({tag, "_data"}, 32'(dif.o_data_d), 32'(expd));
                if (first < 0) first = c;
                last = c;
                n++;
            end
            tick();
        end
        check({tag, "_count"}, 32'(n), 32'(n_exp));
        check({tag, "_gapfree"}, 32'(last - first + 1), 32'(n_exp));
    endtask

    logic [7:0] q [$];
    logic       pv, pr;
    logic [7:0] pd;
    logic [7:0] d;
    logic [AW:0] cnt;
    int rdy_pct;
    int wr_pct;

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        rdata = '0;

        // 1. reset state
        do_reset();
        @(negedge clk);
        check("rst_rptr", 32'(rptr), 32'd0);
        check("rst_ren", 32'(ren), 32'd0);
        check("rst_valid", 32'(dif.o_valid_d), 32'd0);
        check("rst_data", 32'(dif.o_data_d), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_mem_empty", 32'(mem_empty), 32'd1);
        check("rst_almostempty", 32'(almostempty), 32'd1);

        // 2. single word latency
        do_reset();
        wptr = 4'd1;
        @(negedge clk);
        check("sw_ren_c0", 32'(ren), 32'd1);
        check("sw_valid_c0", 32'(dif.o_valid_d), 32'd0);
        tick();
        @(negedge clk);
        check("sw_ren_c1", 32'(ren), 32'd0);
        check("sw_valid_c1", 32'(dif.o_valid_d), 32'd0);
        check("sw_rptr_c1", 32'(rptr), 32'd1);
        check("sw_empty_c1", 32'(empty), 32'd0);
        tick();
        @(negedge clk);
        check("sw_valid_c2", 32'(dif.o_valid_d), 32'd1);
        check("sw_data_c2", 32'(dif.o_data_d), 32'h10);
        check("sw_empty_c2", 32'(empty), 32'd0);
        tick();
        dif.i_ready_d = 1'b1;
        @(negedge clk);
        check("sw_valid_pop", 32'(dif.o_valid_d), 32'd1);
        check("sw_data_pop", 32'(dif.o_data_d), 32'h10);
        tick();
        dif.i_ready_d = 1'b0;
        @(negedge clk);
        check("sw_valid_after", 32'(dif.o_valid_d), 32'd0);
        check("sw_empty_after", 32'(empty), 32'd1);

        // 3. stream 8 words at full rate
        do_reset();
        wptr = 4'd8;
        dif.i_ready_d = 1'b1;
        collect("stream", 16, 8'h10, 8);
        @(negedge clk);
        check("stream_rptr", 32'(rptr), 32'h8);
        check("stream_mem_empty", 32'(mem_empty), 32'd1);
        check("stream_empty", 32'(empty), 32'd1);

        // 4. backpressure
        do_reset();
        wptr = 4'd5;
        repeat (6) tick();
        @(negedge clk);
        check("bp_rptr", 32'(rptr), 32'd2);
        check("bp_valid", 32'(dif.o_valid_d), 32'd1);
        check("bp_data", 32'(dif.o_data_d), 32'h10);
        check("bp_ren", 32'(ren), 32'd0);
        tick();
        dif.i_ready_d = 1'b1;
        collect("bp_release", 10, 8'h10, 5);

        // 5. wrap and almost-empty threshold
        do_reset();
        lvl = 3'd2;
        wptr = 4'd7;
        dif.i_ready_d = 1'b1;
        repeat (12) tick();
        @(negedge clk);
        check("wrap_pre_rptr", 32'(rptr), 32'h7);
        check("wrap_pre_empty", 32'(empty), 32'd1);
        tick();
        dif.i_ready_d = 1'b0;
        wptr = 4'b1010;
        @(negedge clk);
        check("wrap_rptr7", 32'(rptr), 32'h7);
        check("wrap_ae_cnt3", 32'(almostempty), 32'd0);
        check("wrap_ren", 32'(ren), 32'd1);
        check("wrap_mem_empty", 32'(mem_empty), 32'd0);
        tick();
        @(negedge clk);
        check("wrap_rptr8", 32'(rptr), 32'h8);
        check("wrap_ae_cnt2", 32'(almostempty), 32'd1);

        // 6. reset during outstanding read
        do_reset();
        wptr = 4'd5;
        tick();
        tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_rptr", 32'(rptr), 32'd0);
        check("midrst_valid", 32'(dif.o_valid_d), 32'd0);
        check("midrst_data", 32'(dif.o_data_d), 32'd0);
        check("midrst_empty", 32'(empty), 32'd0);
        check("midrst_mem_empty", 32'(mem_empty), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dif.i_ready_d = 1'b1;
        collect("midrst_restart", 12, 8'h10, 5);

        // Randomized traffic against an ordered-queue model.
        do_reset();
        q.delete();
        pv = 1'b0; pr = 1'b0; pd = '0;
        rdy_pct = 50; wr_pct = 50;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if ((cyc % 200) == 0) begin
                rdy_pct = int'($urandom_range(10, 100));
                wr_pct  = int'($urandom_range(10, 100));
            end
            dif.i_ready_d = ($urandom_range(0, 99) < 32'(rdy_pct));
            lvl = 3'($urandom_range(0, 7));
            cnt = wptr - rptr;
            if (cnt < 4'd8 && $urandom_range(0, 99) < 32'(wr_pct)) begin
                d = 8'($urandom);
                mem[wptr[AW-1:0]] = d;
                q.push_back(d);
                wptr = wptr + 4'd1;
            end
            @(negedge clk);
            cnt = wptr - rptr;
            check("rnd_empty", 32'(empty), 32'(q.size() == 0));
            check("rnd_mem_empty", 32'(mem_empty), 32'(wptr == rptr));
            check("rnd_almostempty", 32'(almostempty), 32'(cnt <= {1'b0, lvl}));
            if (pv && !pr) begin
                check("rnd_hold_valid", 32'(dif.o_valid_d), 32'd1);
                check("rnd_hold_data", 32'(dif.o_data_d), 32'(pd));
            end
            if (dif.o_valid_d && dif.i_ready_d) begin
                if (q.size() == 0) begin
                    check("rnd_pop_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rnd_pop_data", 32'(dif.o_data_d), 32'(q.pop_front()));
                end
            end
            pv = dif.o_valid_d;
            pr = dif.i_ready_d;
            pd = dif.o_data_d;
            tick();
        end

        // Drain everything still owed.
        dif.i_ready_d = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dif.o_valid_d) begin
                if (q.size() == 0) begin
                    check("drain_pop_unexpected", 32'd1, 32'd0);
                end else begin
                    check("drain_pop_data", 32'(dif.o_data_d), 32'(q.pop_front()));
                end
            end
            tick();
        end
        @(negedge clk);
        check("drain_queue_empty", 32'(q.size()), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
